uart_tx: RTL and testbench

UART_TX -- requirements
Module: uart_tx

---
 rtl/uart_tx.sv | 155 +++++++++++++++
 tb/tb_uart_tx.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx.sv
// UART transmitter: start bit, NB_DATA data bits (LSB or MSB first), stop period.
// Timing is driven by an external oversampling tick strobe; line, busy and done are registered.
module uart_tx #(
    parameter int unsigned NB_DATA      = 8,
    parameter int unsigned NB_STOP      = 16,
    parameter int unsigned OVERSAMPLING = 16,
    parameter int unsigned MSB_FIRST    = 0
) (
    input  logic               clk,
    input  logic               i_rst,
    input  logic               i_tick,
    input  logic               i_tx_start,
    input  logic [NB_DATA-1:0] i_data,
    output logic               o_tx,
    output logic               o_busy,
    output logic               o_txdone
);

    localparam int unsigned CNT_MAX = (OVERSAMPLING > NB_STOP) ? OVERSAMPLING - 1 : NB_STOP - 1;
    localparam int unsigned CNT_W   = (CNT_MAX > 0) ? $clog2(CNT_MAX + 1) : 1;
    localparam int unsigned IDX_W   = (NB_DATA > 1) ? $clog2(NB_DATA) : 1;

    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(OVERSAMPLING - 1);
    localparam logic [CNT_W-1:0] STOP_LAST = CNT_W'(NB_STOP - 1);
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(NB_DATA - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [NB_DATA-1:0] shreg_q, shreg_d;
    logic               tx_q, tx_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;

    logic [NB_DATA-1:0] shreg_next_c;
    logic               head_c;
    logic               head_next_c;

    // Bit currently at the line-facing end of the shift register, before and after a shift
    always_comb begin
        if (MSB_FIRST != 0) begin
            shreg_next_c = shreg_q << 1;
            head_c       = shreg_q[NB_DATA-1];
            head_next_c  = shreg_next_c[NB_DATA-1];
        end else begin
            shreg_next_c = shreg_q >> 1;
            head_c       = shreg_q[0];
            head_next_c  = shreg_next_c[0];
        end
    end

    // State register; reset wins over every other input
    always_ff @(posedge clk) begin
        if (i_rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            shreg_q <= '0;
            tx_q    <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            shreg_q <= shreg_d;
            tx_q    <= tx_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    // Next-state and next-output logic; without a tick every register holds
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        shreg_d = shreg_q;
        tx_d    = tx_q;
        busy_d  = busy_q;
        done_d  = 1'b0;

        unique case (state_q)
            IDLE: begin
                tx_d   = 1'b1;
                busy_d = 1'b0;
                if (i_tx_start) begin
                    shreg_d = i_data;
                    cnt_d   = '0;
                    idx_d   = '0;
                    state_d = START;
                    tx_d    = 1'b0;
                    busy_d  = 1'b1;
                end
            end
            START: begin
                if (i_tick) begin
                    if (cnt_q == BIT_LAST) begin
                        cnt_d   = '0;
                        idx_d   = '0;
                        state_d = DATA;
                        tx_d    = head_c;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            DATA: begin
                if (i_tick) begin
                    if (cnt_q == BIT_LAST) begin
                        cnt_d   = '0;
                        shreg_d = shreg_next_c;
                        if (idx_q == IDX_LAST) begin
                            state_d = STOP;
                            tx_d    = 1'b1;
                        end else begin
                            idx_d = idx_q + IDX_W'(1);
                            tx_d  = head_next_c;
                        end
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            STOP: begin
                tx_d = 1'b1;
                if (i_tick) begin
                    if (cnt_q == STOP_LAST) begin
                        cnt_d   = '0;
                        state_d = IDLE;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign o_tx     = tx_q;
    assign o_busy   = busy_q;
    assign o_txdone = done_q;

endmodule

// File: tb/tb_uart_tx.sv
// Scoreboard bench for uart_tx: an 8-bit LSB-first and a 32-bit MSB-first instance,
// each decoded by a tick-counting line monitor that checks timing and payload.
module tb_uart_tx;

    localparam int OS  = 16;
    localparam int NBS = 16;

    logic        clk;
    logic        rst;
    logic        tick;
    logic        tick_en;
    logic        start8, start32;
    logic [7:0]  data8;
    logic [31:0] data32;
    logic        tx8, busy8, done8;
    logic        tx32, busy32, done32;

    int n_checks = 0;
    int n_fail   = 0;
    int done_cnt8  = 0;
    int done_cnt32 = 0;
    int div = 0;

    logic [31:0] q8[$];
    logic [31:0] q32[$];

    uart_tx #(.NB_DATA(8), .NB_STOP(NBS), .OVERSAMPLING(OS), .MSB_FIRST(0)) dut8 (
        .clk        (clk),
        .i_rst      (rst),
        .i_tick     (tick),
        .i_tx_start (start8),
        .i_data     (data8),
        .o_tx       (tx8),
        .o_busy     (busy8),
        .o_txdone   (done8)
    );

    uart_tx #(.NB_DATA(32), .NB_STOP(NBS), .OVERSAMPLING(OS), .MSB_FIRST(1)) dut32 (
        .clk        (clk),
        .i_rst      (rst),
        .i_tick     (tick),
        .i_tx_start (start32),
        .i_data     (data32),
        .o_tx       (tx32),
        .o_busy     (busy32),
        .o_txdone   (done32)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One tick every third clock, suppressible to freeze the transmitters
    initial begin
        tick = 1'b0;
        forever begin
            @(negedge clk);
            div  = (div == 2) ? 0 : div + 1;
            tick = tick_en && (div == 2);
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (done8 === 1'b1) done_cnt8++;
            if (done32 === 1'b1) done_cnt32++;
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Decodes one instance's line by counting ticks since the start bit
    task automatic rx_monitor(input bit wide);
        int          nb, k, total, j;
        bit          active;
        logic [31:0] got, exp;
        logic        line, done, busy, tick_at, rst_at;
        string       pfx;
        nb     = wide ? 32 : 8;
        total  = (1 + nb) * OS + NBS;
        active = 1'b0;
        k      = 0;
        got    = '0;
        if (wide) pfx = "w32_"; else pfx = "n8_";
        forever begin
            @(posedge clk);
            tick_at = tick;
            rst_at  = rst;
            if (active && rst_at) begin
                active = 1'b0;
                if (wide) begin
                    if (q32.size() > 0) exp = q32.pop_front();
                end else begin
                    if (q8.size() > 0) exp = q8.pop_front();
                end
            end else if (active && tick_at) begin
                k++;
            end
            @(negedge clk);
            line = wide ? tx32 : tx8;
            done = wide ? done32 : done8;
            busy = wide ? busy32 : busy8;
            if (!active) begin
                if (rst === 1'b0 && line === 1'b0) begin
                    active = 1'b1;
                    k      = 0;
                    got    = '0;
                end
            end else if (tick_at) begin
                if (k == OS / 2) begin
                    check_eq({pfx, "start_bit"}, 32'(line), 32'd0);
                end else if (k >= OS + OS / 2 && k < (nb + 1) * OS && (k % OS) == OS / 2) begin
                    j = k / OS - 1;
                    if (wide) got[nb-1-j] = line;
                    else got[j] = line;
                end else if (k == (nb + 1) * OS + NBS / 2) begin
                    check_eq({pfx, "stop_bit"}, 32'(line), 32'd1);
                end else if (k == total - 1) begin
                    check_eq({pfx, "done_early"}, 32'(done), 32'd0);
                end else if (k == total) begin
                    check_eq({pfx, "done_pulse"}, 32'(done), 32'd1);
                    check_eq({pfx, "busy_at_done"}, 32'(busy), 32'd0);
                    if (wide ? (q32.size() == 0) : (q8.size() == 0)) begin
                        check_eq({pfx, "unexpected_frame"}, 32'd0, 32'd1);
                    end else begin
                        exp = wide ? q32.pop_front() : q8.pop_front();
                        check_eq({pfx, "payload"}, got, exp);
                    end
                    active = 1'b0;
                end
            end
        end
    endtask

    initial begin
        fork
            rx_monitor(1'b0);
            rx_monitor(1'b1);
        join_none
    end

    task automatic send8(input logic [7:0] d);
        start8 = 1'b1;
        data8  = d;
        q8.push_back(32'(d));
        @(negedge clk);
        start8 = 1'b0;
        data8  = ~d;
        check_eq("accept_tx", 32'(tx8), 32'd0);
        check_eq("accept_busy", 32'(busy8), 32'd1);
    endtask

    task automatic wait_done(input bit wide, input int budget);
        int c = 0;
        while ((wide ? done32 : done8) !== 1'b1 && c < budget) begin
            @(negedge clk);
            c++;
        end
        if ((wide ? done32 : done8) !== 1'b1)
            check_eq(wide ? "done32_timeout" : "done8_timeout", 32'd0, 32'd1);
    endtask

    task automatic wait_ticks(input int n);
        int seen = 0;
        int c    = 0;
        while (seen < n && c < 10000) begin
            @(posedge clk);
            if (tick) seen++;
            c++;
        end
        @(negedge clk);
        if (seen < n) check_eq("tick_timeout", 32'(seen), 32'(n));
    endtask

    int cnt_before;

    initial begin
        rst     = 1'b1;
        tick_en = 1'b1;
        start8  = 1'b0;
        start32 = 1'b0;
        data8   = '0;
        data32  = '0;
        repeat (3) @(negedge clk);
        check_eq("rst_tx8", 32'(tx8), 32'd1);
        check_eq("rst_busy8", 32'(busy8), 32'd0);
        check_eq("rst_done8", 32'(done8), 32'd0);
        check_eq("rst_tx32", 32'(tx32), 32'd1);
        check_eq("rst_busy32", 32'(busy32), 32'd0);
        rst = 1'b0;
        data8 = 8'h00;
        repeat (4) @(negedge clk);
        check_eq("idle_tx_data00", 32'(tx8), 32'd1);

        // Basic frame
        send8(8'hA5);
        wait_done(1'b0, 3000);
        repeat (5) @(negedge clk);

        // Back-to-back: start accepted in the done cycle
        send8(8'h5A);
        wait_done(1'b0, 3000);
        send8(8'h3C);
        wait_done(1'b0, 3000);
        repeat (5) @(negedge clk);

        // Start request mid-frame is ignored
        cnt_before = done_cnt8;
        send8(8'h00);
        wait_ticks(40);
        start8 = 1'b1;
        data8  = 8'hFF;
        @(negedge clk);
        start8 = 1'b0;
        wait_done(1'b0, 3000);
        repeat (300) @(negedge clk);
        check_eq("ignored_start_done_cnt", 32'(done_cnt8), 32'(cnt_before + 1));
        check_eq("ignored_start_idle", 32'(busy8), 32'd0);

        // Tick stall mid-bit: bit 3 of 0x96 is 0
        send8(8'h96);
        wait_ticks(70);
        tick_en = 1'b0;
        cnt_before = done_cnt8;
        repeat (2) @(negedge clk);
        check_eq("freeze_tx_begin", 32'(tx8), 32'd0);
        repeat (1000) @(negedge clk);
        check_eq("freeze_tx_end", 32'(tx8), 32'd0);
        check_eq("freeze_busy", 32'(busy8), 32'd1);
        check_eq("freeze_no_done", 32'(done_cnt8), 32'(cnt_before));
        tick_en = 1'b1;
        wait_done(1'b0, 3000);
        repeat (5) @(negedge clk);

        // Reset mid-frame, with a competing start in the same cycle
        send8(8'hC3);
        wait_ticks(70);
        rst    = 1'b1;
        start8 = 1'b1;
        data8  = 8'hFF;
        @(negedge clk);
        check_eq("abort_tx", 32'(tx8), 32'd1);
        check_eq("abort_busy", 32'(busy8), 32'd0);
        check_eq("abort_done", 32'(done8), 32'd0);
        rst    = 1'b0;
        start8 = 1'b0;
        cnt_before = done_cnt8;
        repeat (400) @(negedge clk);
        check_eq("abort_no_done", 32'(done_cnt8), 32'(cnt_before));
        check_eq("abort_idle_tx", 32'(tx8), 32'd1);
        send8(8'h7E);
        wait_done(1'b0, 3000);
        repeat (5) @(negedge clk);

        // Wide MSB-first frame
        start32 = 1'b1;
        data32  = 32'h20010014;
        q32.push_back(32'h20010014);
        @(negedge clk);
        start32 = 1'b0;
        data32  = 32'hFFFFFFFF;
        check_eq("w32_accept_tx", 32'(tx32), 32'd0);
        check_eq("w32_accept_busy", 32'(busy32), 32'd1);
        wait_done(1'b1, 5000);

        repeat (10) @(negedge clk);
        check_eq("q8_drained", 32'(q8.size()), 32'd0);
        check_eq("q32_drained", 32'(q32.size()), 32'd0);
        check_eq("frames8_done", 32'(done_cnt8), 32'd6);
        check_eq("frames32_done", 32'(done_cnt32), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
